// File: rtl/seg7_bin_display.sv
// Registered seven-segment driver: binary value -> decimal (serial shift-and-add-3) or hex digits,
// with leading-zero blanking and overflow dashes, latched once per conversion.
module seg7_bin_display #(
   parameter int DATA_W     = 16,
   parameter int NUM_DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [DATA_W-1:0]       value,
   input  logic                    hex_mode,
   input  logic                    lz_blank,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] seg_out
);

   // ceil(DATA_W * log10(2)) decimal digits are enough for any DATA_W-bit value
   localparam int BCD_D = (DATA_W * 30103 + 99999) / 100000;
   localparam int HEX_D = (DATA_W + 3) / 4;
   localparam int TOT_A = (BCD_D > HEX_D) ? BCD_D : HEX_D;
   localparam int TOT   = (TOT_A > NUM_DIGITS) ? TOT_A : NUM_DIGITS;
   localparam int BCD_W = 4 * BCD_D;
   localparam int PAD_W = 4 * TOT;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int SEG_W = 7 * NUM_DIGITS;

   typedef enum logic [1:0] {IDLE, CONV, DISP} state_t;

   state_t             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               hex_q, hex_d;
   logic               lz_q, lz_d;
   logic [SEG_W-1:0]   seg_q, seg_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic [BCD_W-1:0]        bcd_adj;
   logic [BCD_W+DATA_W-1:0] cat;
   logic [PAD_W-1:0]        digits_pad;
   logic                    ovf_calc;
   logic [SEG_W-1:0]        seg_calc;
   logic                    seen;
   logic [3:0]              nib;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'h0: seg_code = 7'b0000001;
         4'h1: seg_code = 7'b1001111;
         4'h2: seg_code = 7'b0010010;
         4'h3: seg_code = 7'b0000110;
         4'h4: seg_code = 7'b1001100;
         4'h5: seg_code = 7'b0100100;
         4'h6: seg_code = 7'b0100000;
         4'h7: seg_code = 7'b0001111;
         4'h8: seg_code = 7'b0000000;
         4'h9: seg_code = 7'b0000100;
         4'hA: seg_code = 7'b0001000;
         4'hB: seg_code = 7'b1100000;
         4'hC: seg_code = 7'b0110001;
         4'hD: seg_code = 7'b1000010;
         4'hE: seg_code = 7'b0110000;
         default: seg_code = 7'b0111000;
      endcase
   endfunction

   // Double-dabble step: correct each BCD nibble, then shift BCD and binary together
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < BCD_D; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      end
      cat = {bcd_adj, shift_q} << 1;
   end

   // Digit source and display formatting; hex digits live in shift_q, which is never shifted in hex mode
   always_comb begin
      digits_pad = hex_q ? PAD_W'(shift_q) : PAD_W'(bcd_q);
      ovf_calc   = 1'b0;
      seg_calc   = '1;
      seen       = 1'b0;
      nib        = 4'd0;
      for (int i = NUM_DIGITS; i < TOT; i++) begin
         if (digits_pad[4*i +: 4] != 4'd0) ovf_calc = 1'b1;
      end
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nib = digits_pad[4*i +: 4];
         if (nib != 4'd0) seen = 1'b1;
         if (ovf_calc)                     seg_calc[7*i +: 7] = 7'b1111110;
         else if (lz_q && !seen && i != 0) seg_calc[7*i +: 7] = 7'b1111111;
         else                              seg_calc[7*i +: 7] = seg_code(nib);
      end
   end

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      hex_d   = hex_q;
      lz_d    = lz_q;
      seg_d   = seg_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               hex_d   = hex_mode;
               lz_d    = lz_blank;
               shift_d = value;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = hex_mode ? DISP : CONV;
            end
         end
         CONV: begin
            bcd_d   = cat[BCD_W+DATA_W-1:DATA_W];
            shift_d = cat[DATA_W-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DISP;
         end
         DISP: begin
            seg_d   = seg_calc;
            ovf_d   = ovf_calc;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         hex_q   <= 1'b0;
         lz_q    <= 1'b0;
         seg_q   <= '1;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         hex_q   <= hex_d;
         lz_q    <= lz_d;
         seg_q   <= seg_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign overflow = ovf_q;
   assign seg_out  = seg_q;

endmodule

// File: tb/tb_seg7_bin_display.sv
// Bench for seg7_bin_display: a 5-digit and a 4-digit instance share one stimulus stream and are
// checked every cycle against an arithmetic model, plus hand-computed digit codes.
module tb_seg7_bin_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load = 1'b0;
   logic        hex_mode = 1'b0;
   logic        lz_blank = 1'b0;
   logic [15:0] value = 16'd0;

   logic        busy5, done5, ovf5;
   logic [34:0] seg5;
   logic        busy4, done4, ovf4;
   logic [27:0] seg4;

   int total = 0;
   int bad = 0;

   localparam logic [6:0] BLK = 7'b1111111;
   localparam logic [6:0] DSH = 7'b1111110;

   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   seg7_bin_display #(.DATA_W(16), .NUM_DIGITS(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .hex_mode(hex_mode),
      .lz_blank(lz_blank), .busy(busy5), .done(done5), .overflow(ovf5), .seg_out(seg5));

   seg7_bin_display #(.DATA_W(16), .NUM_DIGITS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .hex_mode(hex_mode),
      .lz_blank(lz_blank), .busy(busy4), .done(done4), .overflow(ovf4), .seg_out(seg4));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int digit_of(input int v, input int base, input int i);
      int p = 1;
      for (int k = 0; k < i; k++) p *= base;
      return (v / p) % base;
   endfunction

   function automatic bit model_ovf(input int v, input bit h, input int nd);
      longint lim = 1;
      for (int i = 0; i < nd; i++) lim *= (h ? 16 : 10);
      return (longint'(v) >= lim);
   endfunction

   function automatic logic [55:0] model_seg(input int v, input bit h, input bit lz, input int nd);
      logic [55:0] r;
      int base;
      int top;
      r = '1;
      base = h ? 16 : 10;
      if (model_ovf(v, h, nd)) begin
         for (int i = 0; i < nd; i++) r[7*i +: 7] = DSH;
         return r;
      end
      top = 0;
      for (int i = 0; i < nd; i++) if (digit_of(v, base, i) != 0) top = i;
      for (int i = 0; i < nd; i++) begin
         if (lz && i > top) r[7*i +: 7] = BLK;
         else               r[7*i +: 7] = seg_tab[digit_of(v, base, i)];
      end
      return r;
   endfunction

   int          remain = 0;
   bit          exp_done = 1'b0;
   bit          exp_ovf5 = 1'b0, exp_ovf4 = 1'b0, pend_ovf5 = 1'b0, pend_ovf4 = 1'b0;
   logic [34:0] exp_seg5 = '1, pend5 = '1;
   logic [27:0] exp_seg4 = '1, pend4 = '1;
   logic [55:0] tmp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remain = 0; exp_done = 1'b0;
         exp_seg5 = '1; exp_seg4 = '1; exp_ovf5 = 1'b0; exp_ovf4 = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (remain > 0) begin
            remain--;
            if (remain == 0) begin
               exp_seg5 = pend5; exp_seg4 = pend4;
               exp_ovf5 = pend_ovf5; exp_ovf4 = pend_ovf4;
               exp_done = 1'b1;
            end
         end else if (load) begin
            tmp = model_seg(int'(value), hex_mode, lz_blank, 5); pend5 = tmp[34:0];
            tmp = model_seg(int'(value), hex_mode, lz_blank, 4); pend4 = tmp[27:0];
            pend_ovf5 = model_ovf(int'(value), hex_mode, 5);
            pend_ovf4 = model_ovf(int'(value), hex_mode, 4);
            remain = hex_mode ? 1 : 17;
         end
      end
   end

   always @(negedge clk) begin
      check("busy5", busy5, remain > 0);
      check("done5", done5, exp_done);
      check("ovf5", ovf5, exp_ovf5);
      check("seg5", seg5, exp_seg5);
      check("busy4", busy4, remain > 0);
      check("done4", done4, exp_done);
      check("ovf4", ovf4, exp_ovf4);
      check("seg4", seg4, exp_seg4);
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; load is seen by the next rising edge, value is scrambled afterwards.
   task automatic do_load(input logic [15:0] v, input logic h, input logic lz);
      load = 1'b1; value = v; hex_mode = h; lz_blank = lz;
      @(negedge clk);
      load = 1'b0;
      value = 16'($urandom_range(0, 65535));
      hex_mode = 1'($urandom_range(0, 1));
      lz_blank = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(input int lat, input string nm);
      int n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (done5) break;
      end
      check(nm, n, lat);
   endtask

   initial begin
      bit seen_done;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      tmp = model_seg(1234, 1'b0, 1'b0, 5);
      check("model_1234", tmp[34:0], {7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
      tmp = model_seg(16'h00BE, 1'b1, 1'b1, 5);
      check("model_hex", tmp[34:0], {BLK, BLK, BLK, 7'b1100000, 7'b0110000});

      do_load(16'd1234, 1'b0, 1'b0);
      wait_done(17, "lat_1234");
      check("lit_1234_seg5", seg5, {7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
      check("lit_1234_ovf5", ovf5, 1'b0);
      check("lit_1234_seg4", seg4, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});

      @(negedge clk);
      do_load(16'h00BE, 1'b1, 1'b1);
      wait_done(1, "lat_hex");
      check("lit_hex_seg5", seg5, {BLK, BLK, BLK, 7'b1100000, 7'b0110000});

      @(negedge clk);
      do_load(16'd12345, 1'b0, 1'b0);
      wait_done(17, "lat_12345");
      check("lit_12345_ovf4", ovf4, 1'b1);
      check("lit_12345_seg4", seg4, {4{DSH}});
      check("lit_12345_ovf5", ovf5, 1'b0);
      check("lit_12345_seg5", seg5, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100});
      repeat (3) @(negedge clk);
      check("ovf4_held", ovf4, 1'b1);

      do_load(16'd500, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      load = 1'b1; value = 16'd999;
      @(negedge clk);
      load = 1'b0;
      wait_done(12, "lat_500_busy");
      check("lit_500_seg5", seg5[20:0], {7'b0100100, 7'b0000001, 7'b0000001});

      @(negedge clk);
      do_load(16'd777, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_seg5", seg5, {35{1'b1}});
      check("rst_seg4", seg4, {28{1'b1}});
      check("rst_busy", busy5, 1'b0);
      check("rst_done", done5, 1'b0);
      check("rst_ovf", ovf4, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done5) seen_done = 1'b1;
      end
      check("no_done_after_abort", seen_done, 1'b0);

      do_load(16'd0, 1'b0, 1'b1);
      wait_done(17, "lat_zero");
      check("lit_zero_seg5", seg5, {BLK, BLK, BLK, BLK, 7'b0000001});
      do_load(16'd42, 1'b0, 1'b1);
      wait_done(17, "lat_b2b_42");
      check("lit_42_low", seg5[13:0], {7'b1001100, 7'b0010010});
      check("lit_42_high", seg5[34:14], {BLK, BLK, BLK});

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
